// File: rtl/config_chain_loader.sv
// Serial configuration shift chain with an atomic shadow register. A commit is
// accepted only when exactly DEPTH words have been shifted since the last commit/clear.
module config_chain_loader #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                     clock,
  input  logic                     nreset,
  input  logic [WIDTH-1:0]         shift_in_data,
  input  logic                     shift_in_valid,
  output logic [WIDTH-1:0]         shift_out_data,
  input  logic                     commit,
  input  logic                     clear,
  output logic [WIDTH*DEPTH-1:0]   config_out,
  output logic                     config_valid,
  output logic [CW-1:0]            shift_count,
  output logic [1:0]               state,
  output logic                     error
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_FULL    = 2'd2,
    ST_OVERRUN = 2'd3
  } state_t;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0]       chain_q [DEPTH];
  logic [WIDTH-1:0]       chain_d [DEPTH];
  logic [WIDTH*DEPTH-1:0] chain_flat;
  logic [WIDTH*DEPTH-1:0] shadow_q, shadow_d;
  logic [CW-1:0]          count_q, count_d, base_count, inc_count;
  state_t                 state_q, state_d, base_state;
  logic                   error_q, error_d;
  logic                   valid_q, valid_d;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign chain_flat[gi*WIDTH +: WIDTH] = chain_q[gi];
    end
  endgenerate

  always_comb begin
    chain_d    = chain_q;
    shadow_d   = shadow_q;
    count_d    = count_q;
    state_d    = state_q;
    error_d    = error_q;
    valid_d    = valid_q;
    base_count = count_q;
    base_state = state_q;
    inc_count  = '0;

    if (clear) begin
      for (int i = 0; i < DEPTH; i++) chain_d[i] = '0;
      count_d = '0;
      state_d = ST_EMPTY;
      error_d = 1'b0;
    end else begin
      // Commit judges the pre-edge chain; a same-cycle shift then starts a fresh load.
      if (commit) begin
        if (state_q == ST_FULL) begin
          shadow_d = chain_flat;
          valid_d  = 1'b1;
          error_d  = 1'b0;
        end else begin
          error_d  = 1'b1;
        end
        base_count = '0;
        base_state = ST_EMPTY;
      end

      if (shift_in_valid) begin
        chain_d[0] = shift_in_data;
        for (int i = 1; i < DEPTH; i++) chain_d[i] = chain_q[i-1];
        inc_count = (base_count == DEPTH_C) ? DEPTH_C : base_count + CW'(1);
        count_d   = inc_count;
        case (base_state)
          ST_EMPTY, ST_LOADING: state_d = (inc_count == DEPTH_C) ? ST_FULL : ST_LOADING;
          default:              state_d = ST_OVERRUN;
        endcase
      end else begin
        count_d = base_count;
        state_d = base_state;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      for (int i = 0; i < DEPTH; i++) chain_q[i] <= '0;
      shadow_q <= '0;
      count_q  <= '0;
      state_q  <= ST_EMPTY;
      error_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) chain_q[i] <= chain_d[i];
      shadow_q <= shadow_d;
      count_q  <= count_d;
      state_q  <= state_d;
      error_q  <= error_d;
      valid_q  <= valid_d;
    end
  end

  assign shift_out_data = chain_q[DEPTH-1];
  assign config_out     = shadow_q;
  assign config_valid   = valid_q;
  assign shift_count    = count_q;
  assign state          = state_q;
  assign error          = error_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader (WIDTH=2, DEPTH=4): directed vector table,
// hand sequences and random traffic against a words-since-commit reference model.
module tb_config_chain_loader;

  localparam int WIDTH = 2;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic             clock = 1'b0;
  logic             nreset;
  logic [WIDTH-1:0] shift_in_data;
  logic             shift_in_valid;
  logic [WIDTH-1:0] shift_out_data;
  logic             commit;
  logic             clear;
  logic [WIDTH*DEPTH-1:0] config_out;
  logic             config_valid;
  logic [CW-1:0]    shift_count;
  logic [1:0]       state;
  logic             error;

  int checks   = 0;
  int failures = 0;

  config_chain_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .nreset         (nreset),
    .shift_in_data  (shift_in_data),
    .shift_in_valid (shift_in_valid),
    .shift_out_data (shift_out_data),
    .commit         (commit),
    .clear          (clear),
    .config_out     (config_out),
    .config_valid   (config_valid),
    .shift_count    (shift_count),
    .state          (state),
    .error          (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst_n, sv;
    logic [1:0] sd;
    logic       cm, cl;
    logic [7:0] cfg;
    logic       cv;
    logic [2:0] cnt;
    logic [1:0] st;
    logic       er;
    logic [1:0] so;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic rst_n, logic sv, logic [1:0] sd, logic cm, logic cl,
                             logic [7:0] cfg, logic cv, logic [2:0] cnt, logic [1:0] st,
                             logic er, logic [1:0] so);
    vec_t r;
    r.rst_n = rst_n; r.sv = sv; r.sd = sd; r.cm = cm; r.cl = cl;
    r.cfg = cfg; r.cv = cv; r.cnt = cnt; r.st = st; r.er = er; r.so = so;
    return r;
  endfunction

  task automatic check(string name, int actual, int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Reference model: n counts words shifted since the last commit/clear (capped above DEPTH);
  // state and count are derived from it rather than tracked as a machine.
  int         m_n;
  logic [1:0] m_words [DEPTH];
  logic [7:0] m_shadow;
  logic       m_cv, m_err;

  task automatic model_step(logic rst_n, logic sv, logic [1:0] sd, logic cm, logic cl);
    if (!rst_n) begin
      m_n = 0; m_shadow = '0; m_cv = 0; m_err = 0;
      for (int i = 0; i < DEPTH; i++) m_words[i] = '0;
    end else if (cl) begin
      m_n = 0; m_err = 0;
      for (int i = 0; i < DEPTH; i++) m_words[i] = '0;
    end else begin
      if (cm) begin
        if (m_n == DEPTH) begin
          for (int i = 0; i < DEPTH; i++) m_shadow[i*WIDTH +: WIDTH] = m_words[i];
          m_cv = 1; m_err = 0;
        end else m_err = 1;
        m_n = 0;
      end
      if (sv) begin
        for (int i = DEPTH-1; i > 0; i--) m_words[i] = m_words[i-1];
        m_words[0] = sd;
        if (m_n <= DEPTH) m_n++;
      end
    end
  endtask

  task automatic drive(logic rst_n, logic sv, logic [1:0] sd, logic cm, logic cl);
    nreset = rst_n; shift_in_valid = sv; shift_in_data = sd; commit = cm; clear = cl;
    @(posedge clock);
    #1;
  endtask

  task automatic model_cycle(string tag, logic rst_n, logic sv, logic [1:0] sd, logic cm, logic cl);
    int exp_st;
    drive(rst_n, sv, sd, cm, cl);
    model_step(rst_n, sv, sd, cm, cl);
    exp_st = (m_n == 0) ? 0 : (m_n < DEPTH) ? 1 : (m_n == DEPTH) ? 2 : 3;
    check({tag, " cfg"},   config_out, m_shadow);
    check({tag, " cv"},    config_valid, m_cv);
    check({tag, " count"}, shift_count, (m_n > DEPTH) ? DEPTH : m_n);
    check({tag, " state"}, state, exp_st);
    check({tag, " error"}, error, m_err);
    check({tag, " sout"},  shift_out_data, m_words[DEPTH-1]);
    $display("%s rst_n=%0b sv=%0b sd=%0d cm=%0b cl=%0b -> cfg=%02h cv=%0b cnt=%0d st=%0d err=%0b",
             tag, rst_n, sv, sd, cm, cl, config_out, config_valid, shift_count, state, error);
  endtask

  initial begin
    nreset = 0; shift_in_valid = 0; shift_in_data = '0; commit = 0; clear = 0;

    //            rst sv sd cm cl   cfg   cv cnt st er so
    tbl.push_back(v(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));  // reset state
    tbl.push_back(v(1, 1, 0, 0, 0, 8'h00, 0, 1, 1, 0, 0));
    tbl.push_back(v(1, 1, 1, 0, 0, 8'h00, 0, 2, 1, 0, 0));
    tbl.push_back(v(1, 1, 2, 0, 0, 8'h00, 0, 3, 1, 0, 0));
    tbl.push_back(v(1, 1, 3, 0, 0, 8'h00, 0, 4, 2, 0, 0));
    tbl.push_back(v(1, 0, 0, 1, 0, 8'h1B, 1, 0, 0, 0, 0));  // good commit
    tbl.push_back(v(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 1, 0, 0, 8'h00, 0, 1, 1, 0, 0));
    tbl.push_back(v(1, 1, 2, 0, 0, 8'h00, 0, 2, 1, 0, 0));
    tbl.push_back(v(1, 1, 3, 0, 0, 8'h00, 0, 3, 1, 0, 0));
    tbl.push_back(v(1, 0, 0, 1, 0, 8'h00, 0, 0, 0, 1, 0));  // short commit
    tbl.push_back(v(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 8'h00, 0, 1, 1, 0, 0));
    tbl.push_back(v(1, 1, 1, 0, 0, 8'h00, 0, 2, 1, 0, 0));
    tbl.push_back(v(1, 1, 2, 0, 0, 8'h00, 0, 3, 1, 0, 0));
    tbl.push_back(v(1, 1, 3, 0, 0, 8'h00, 0, 4, 2, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 8'h00, 0, 4, 3, 0, 1));  // overrun
    tbl.push_back(v(1, 0, 0, 1, 0, 8'h00, 0, 0, 0, 1, 1));
    tbl.push_back(v(1, 1, 2, 0, 0, 8'h00, 0, 1, 1, 1, 2));
    tbl.push_back(v(1, 1, 3, 0, 0, 8'h00, 0, 2, 1, 1, 3));
    tbl.push_back(v(1, 1, 1, 0, 0, 8'h00, 0, 3, 1, 1, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 8'h00, 0, 4, 2, 1, 2));
    tbl.push_back(v(1, 1, 3, 1, 0, 8'hB4, 1, 1, 1, 0, 3));  // commit + shift
    tbl.push_back(v(1, 1, 1, 0, 0, 8'hB4, 1, 2, 1, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));  // reset mid-load
    tbl.push_back(v(1, 1, 1, 0, 0, 8'h00, 0, 1, 1, 0, 0));
    tbl.push_back(v(1, 1, 2, 0, 0, 8'h00, 0, 2, 1, 0, 0));
    tbl.push_back(v(1, 1, 3, 0, 0, 8'h00, 0, 3, 1, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 8'h00, 0, 4, 2, 0, 1));
    tbl.push_back(v(1, 0, 0, 1, 0, 8'h6C, 1, 0, 0, 0, 1));
    tbl.push_back(v(1, 1, 2, 0, 0, 8'h6C, 1, 1, 1, 0, 2));
    tbl.push_back(v(1, 1, 3, 0, 0, 8'h6C, 1, 2, 1, 0, 3));
    tbl.push_back(v(1, 1, 1, 1, 1, 8'h6C, 1, 0, 0, 0, 0));  // clear beats commit/shift
    tbl.push_back(v(1, 0, 0, 1, 0, 8'h6C, 1, 0, 0, 1, 0));
    tbl.push_back(v(1, 0, 0, 0, 1, 8'h6C, 1, 0, 0, 0, 0));  // clear drops error

    for (int r = 0; r < tbl.size(); r++) begin
      string tag;
      tag = $sformatf("vec%0d", r);
      drive(tbl[r].rst_n, tbl[r].sv, tbl[r].sd, tbl[r].cm, tbl[r].cl);
      check({tag, " cfg"},   config_out, tbl[r].cfg);
      check({tag, " cv"},    config_valid, tbl[r].cv);
      check({tag, " count"}, shift_count, tbl[r].cnt);
      check({tag, " state"}, state, tbl[r].st);
      check({tag, " error"}, error, tbl[r].er);
      check({tag, " sout"},  shift_out_data, tbl[r].so);
      $display("%s cfg=%02h cv=%0b cnt=%0d st=%0d err=%0b sout=%0d",
               tag, config_out, config_valid, shift_count, state, error, shift_out_data);
    end

    // Hand sequence: full chain idles without drifting, then commits; then a
    // commit+shift from OVERRUN is rejected but still starts a new load.
    model_cycle("hs_rst", 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) model_cycle("hs_load", 1, 1, 2'(i + 1), 0, 0);
    for (int i = 0; i < 3; i++) model_cycle("hs_idle", 1, 0, 2'(i), 0, 0);
    model_cycle("hs_commit", 1, 0, 0, 1, 0);
    for (int i = 0; i < DEPTH + 2; i++) model_cycle("hs_over", 1, 1, 2'(3 - i), 0, 0);
    model_cycle("hs_ovcs", 1, 1, 2, 1, 0);

    // Random traffic; commits are frequent enough that some land exactly at DEPTH.
    for (int i = 0; i < 600; i++) begin
      logic rst_n, sv, cm, cl;
      logic [1:0] sd;
      rst_n = ($urandom_range(0, 99) >= 2);
      sv    = ($urandom_range(0, 99) < 65);
      cm    = ($urandom_range(0, 99) < 18);
      cl    = ($urandom_range(0, 99) < 3);
      sd    = 2'($urandom_range(0, 3));
      model_cycle($sformatf("rnd%0d", i), rst_n, sv, sd, cm, cl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Parametrised configuration shift chain for FPGA-fabric tiles: WIDTH-bit words shifted serially through DEPTH stages.
- Shadow register latches the chain atomically on commit, so fabric config never sees partially shifted data.
- Shift counter plus state machine validates the exact word count; a tail output allows daisy-chaining tiles.

Parameters:
- WIDTH, 1, bits per chain stage (per shift).
- DEPTH, 8, number of stages in the chain.
- CW, $clog2(DEPTH+1), width of shift_count.

Ports:
- clock  input  1  rising-edge clock.
- nreset  input  1  synchronous, active-low reset.
- shift_in_data  input  WIDTH  word entering stage 0.
- shift_in_valid  input  1  shift enable; one word per cycle while high.
- shift_out_data  output  WIDTH  current content of stage DEPTH-1 (registered, no logic); daisy-chain tail.
- commit  input  1  request to copy chain into shadow.
- clear  input  1  zero chain, count and flags; shadow untouched.
- config_out  output  WIDTH*DEPTH  shadow register; stage i at bits [i*WIDTH +: WIDTH].
- config_valid  output  1  high once any commit has succeeded.
- shift_count  output  CW  shifts since last commit/clear, saturating at DEPTH.
- state  output  2  0=EMPTY, 1=LOADING, 2=FULL, 3=OVERRUN.
- error  output  1  sticky: last commit was rejected.

Behaviour:
- Reset (nreset=0 at a clock edge):
  - chain, shadow, count, error and config_valid go to 0; state goes to EMPTY.
  - Reset mid-load discards the partial load.
- Shift (shift_in_valid=1):
  - stage0 <= shift_in_data; stage i <= stage i-1.
  - Old stage DEPTH-1 is discarded; it was visible on shift_out_data during that cycle.
- Counter: increments per shift and saturates at DEPTH.
- State transitions on shift:
  - EMPTY -> LOADING (DEPTH=1: EMPTY -> FULL).
  - LOADING -> FULL when count reaches DEPTH.
  - FULL -> OVERRUN on any further shift.
  - OVERRUN holds until commit or clear.
- Commit (evaluated on pre-edge count/state):
  - state FULL: shadow <= pre-shift chain; config_valid <= 1; error <= 0. config_out updates 1 cycle after commit.
  - any other state: shadow unchanged; error <= 1.
  - In both cases count <= 0 and state <= EMPTY, unless a shift occurs in the same cycle.
- Simultaneous shift + commit:
  - commit uses the pre-shift chain and count.
  - The shift still occurs; afterwards count=1 and state=LOADING (FULL if DEPTH=1).
- Clear:
  - Highest priority after reset; overrides shift and commit in the same cycle.
  - chain=0, count=0, error=0, state=EMPTY; shadow and config_valid are kept.
- Priority order: reset > clear > commit/shift.
- Chain content is never modified except by shift, clear or reset.

Test Plan:
- WIDTH=2, DEPTH=4, shift 0,1,2,3 then commit -> next cycle config_out=8'b00_01_10_11 (stage0=3), config_valid=1, error=0, state=EMPTY, count=0.
- Shift 3 words then commit -> error=1, config_out unchanged (0 after reset), config_valid stays 0.
- Shift 5 words (0..4) -> state=OVERRUN, count=4, shift_out_data showed 0 during 5th shift. Then commit -> error=1, shadow unchanged.
- Shift 4 words A, then commit with simultaneous shift of word B -> shadow holds A set, count=1, state=LOADING, stage0=B.
- Mid-load (2 of 4) assert nreset=0 for 1 cycle -> all outputs 0, state=EMPTY. Then 4 shifts + commit -> success.
- After a successful commit, shift 2 words then assert clear with commit -> chain=0, count=0, error=0, shadow and config_valid retained.
